// File: rtl/hex_dumper.sv
// Streams a memory region as Intel HEX text: data records of up to BYTES_PER_LINE bytes,
// then the EOF record. Memory has one-cycle read latency; output is a valid/ready byte stream.
module hex_dumper #(
    parameter int unsigned BYTES_PER_LINE = 16
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic        start,
    input  logic [14:0] base_addr,
    input  logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        mem_rd,
    output logic [14:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam logic [15:0] LineMax = 16'(BYTES_PER_LINE);

    typedef enum logic [4:0] {
        StIdle, StColon, StLenH, StLenL, StAddr3, StAddr2, StAddr1, StAddr0, StTypeH, StTypeL,
        StFetch, StWait, StDataH, StDataL, StChkH, StChkL, StCr, StLf, StDone
    } state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    state_e      state_q, state_d;
    logic [14:0] addr_q;
    logic [15:0] remaining_q;
    logic [14:0] rec_addr_q;
    logic [7:0]  rec_len_q, byte_cnt_q, sum_q, data_q;
    logic        eof_q;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;

    logic        hs, is_char, load_rec, new_eof;
    logic [7:0]  cur_char, new_len, new_sum, chk;
    logic [15:0] src_remaining;
    logic [14:0] src_addr;

    assign hs  = out_valid_q & out_ready;
    assign chk = ~sum_q + 8'd1;

    // A record is sized from the start inputs on the first record, from the running state after.
    // A record with nothing left to send becomes the EOF record.
    always_comb begin
        src_remaining = (state_q == StIdle) ? length : remaining_q;
        src_addr      = (state_q == StIdle) ? base_addr : addr_q;
        new_eof       = (src_remaining == 16'd0);
        new_len       = (src_remaining > LineMax) ? LineMax[7:0] : src_remaining[7:0];
        new_sum       = new_eof ? 8'h01 : (new_len + {1'b0, src_addr[14:8]} + src_addr[7:0]);
        load_rec      = (state_d == StColon) && (state_q != StColon);
    end

    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            rec_addr_q  <= '0;
            rec_len_q   <= '0;
            byte_cnt_q  <= '0;
            sum_q       <= '0;
            data_q      <= '0;
            eof_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (load_rec) begin
                rec_len_q   <= new_len;
                byte_cnt_q  <= new_len;
                rec_addr_q  <= new_eof ? 15'd0 : src_addr;
                sum_q       <= new_sum;
                eof_q       <= new_eof;
                remaining_q <= src_remaining - {8'h00, new_len};
                if (state_q == StIdle) addr_q <= base_addr;
            end
            if (state_q == StFetch) addr_q <= addr_q + 15'd1;
            if (state_q == StWait) begin
                data_q     <= mem_data;
                sum_q      <= sum_q + mem_data;
                byte_cnt_q <= byte_cnt_q - 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StColon;
            StColon, StLenH, StLenL, StAddr3, StAddr2, StAddr1, StAddr0, StTypeH,
            StDataH, StChkH, StChkL, StCr: begin
                if (hs) state_d = state_e'(state_q + 5'd1);
            end
            StTypeL, StDataL: begin
                if (hs) state_d = (byte_cnt_q != 8'd0) ? StFetch : StChkH;
            end
            StFetch: state_d = StWait;
            StWait:  state_d = StDataH;
            StLf:    if (hs) state_d = eof_q ? StDone : StColon;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The character register is refilled from the current state; it drops for one cycle after
    // each handshake so a character is never presented twice.
    always_comb begin
        is_char  = 1'b1;
        cur_char = 8'h00;
        unique case (state_q)
            StColon: cur_char = 8'h3A;
            StLenH:  cur_char = hex_char(rec_len_q[7:4]);
            StLenL:  cur_char = hex_char(rec_len_q[3:0]);
            StAddr3: cur_char = hex_char({1'b0, rec_addr_q[14:12]});
            StAddr2: cur_char = hex_char(rec_addr_q[11:8]);
            StAddr1: cur_char = hex_char(rec_addr_q[7:4]);
            StAddr0: cur_char = hex_char(rec_addr_q[3:0]);
            StTypeH: cur_char = 8'h30;
            StTypeL: cur_char = eof_q ? 8'h31 : 8'h30;
            StDataH: cur_char = hex_char(data_q[7:4]);
            StDataL: cur_char = hex_char(data_q[3:0]);
            StChkH:  cur_char = hex_char(chk[7:4]);
            StChkL:  cur_char = hex_char(chk[3:0]);
            StCr:    cur_char = 8'h0D;
            StLf:    cur_char = 8'h0A;
            default: is_char = 1'b0;
        endcase
        out_valid_d = is_char & ~hs;
        out_data_d  = out_valid_d ? cur_char : 8'h00;
        busy        = (state_q != StIdle) && (state_q != StDone);
        done        = (state_q == StDone);
        mem_rd      = (state_q == StFetch);
        mem_addr    = addr_q;
        out_valid   = out_valid_q;
        out_data    = out_data_q;
    end

endmodule

// File: tb/tb_hex_dumper.sv
// Directed bench for hex_dumper: table of dumps with hand-computed Intel HEX text,
// plus reset, latency and start-while-busy sequences.
module tb_hex_dumper;

    logic        clk_74a = 1'b0;
    logic        reset_n;
    logic        start;
    logic [14:0] base_addr;
    logic [15:0] length;
    logic        busy, done, mem_rd, out_valid, out_ready;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data, out_data;

    always #5 clk_74a = ~clk_74a;

    hex_dumper #(.BYTES_PER_LINE(16)) dut (
        .clk_74a   (clk_74a),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    // Memory: data appears exactly one cycle after the read strobe, garbage otherwise.
    logic [7:0]  mem [0:32767];
    logic        rd_del = 1'b0;
    logic [14:0] addr_del = '0;
    always @(posedge clk_74a) begin
        rd_del   <= mem_rd;
        addr_del <= mem_addr;
    end
    assign mem_data = rd_del ? mem[addr_del] : 8'hEE;

    int checks = 0;
    int errors = 0;

    logic [7:0]  got_q[$];
    logic [14:0] addr_log[$];
    int          rd_cnt, done_cnt, stab_err;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always @(negedge clk_74a) begin
        if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_err++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (mem_rd) begin
            rd_cnt++;
            addr_log.push_back(mem_addr);
        end
        if (done) done_cnt++;
    end

    // Sink: always ready, or random with bursts of 5-cycle stalls.
    int ready_mode = 0;
    int stall_left = 0;
    always @(posedge clk_74a) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if ($urandom_range(0, 3) == 0) begin
            out_ready  = 1'b0;
            stall_left = 4;
        end else out_ready = 1'b1;
    end

    typedef struct {
        logic [14:0] base;
        logic [15:0] len;
        int          mem_mode;
        int          ready_mode;
        bit          glitch;
        string       exp;
    } vec_t;

    vec_t vecs[6];

    task automatic set_vec(input int idx, input logic [14:0] b, input logic [15:0] l,
                           input int mm, input int rm, input bit g, input string e);
        vecs[idx].base       = b;
        vecs[idx].len        = l;
        vecs[idx].mem_mode   = mm;
        vecs[idx].ready_mode = rm;
        vecs[idx].glitch     = g;
        vecs[idx].exp        = e;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int a = 0; a < 32768; a++) mem[a] = 8'(a);
        if (mode == 1) begin
            mem[16] = 8'h01;
            mem[17] = 8'h02;
            mem[18] = 8'h03;
        end else if (mode == 2) begin
            mem[32767] = 8'hAB;
            mem[0]     = 8'hCD;
        end
    endtask

    function automatic string to_text(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) begin
            if (s.len() < 200) begin
                if (q[i] == 8'h0D) s = {s, "<CR>"};
                else if (q[i] == 8'h0A) s = {s, "<LF>"};
                else s = $sformatf("%s%c", s, q[i]);
            end
        end
        return s;
    endfunction

    task automatic run_vec(input int idx);
        vec_t       v;
        logic [7:0] exp_q[$];
        bit         ok, found;
        v = vecs[idx];
        fill_mem(v.mem_mode);
        ready_mode = v.ready_mode;
        stall_left = 0;
        @(posedge clk_74a);
        #2;
        got_q.delete();
        addr_log.delete();
        rd_cnt = 0;
        done_cnt = 0;
        stab_err = 0;
        start = 1'b1;
        base_addr = v.base;
        length = v.len;
        @(negedge clk_74a);
        check($sformatf("v%0d busy_in_start_cycle", idx), busy, 0);
        @(posedge clk_74a);
        #2;
        start = 1'b0;
        base_addr = 15'h1234;
        length = 16'd99;
        @(negedge clk_74a);
        check($sformatf("v%0d busy_t1", idx), busy, 1);
        check($sformatf("v%0d valid_t1", idx), out_valid, 0);
        @(negedge clk_74a);
        check($sformatf("v%0d colon_t2", idx), {out_valid, out_data}, {1'b1, 8'h3A});
        if (v.glitch) begin
            repeat (6) @(posedge clk_74a);
            #2;
            start = 1'b1;
            base_addr = 15'h0000;
            length = 16'd5;
            @(posedge clk_74a);
            #2;
            start = 1'b0;
        end
        found = 1'b0;
        for (int c = 0; c < 4000 && !found; c++) begin
            @(negedge clk_74a);
            if (done) found = 1'b1;
        end
        check($sformatf("v%0d done_seen", idx), found, 1);
        check($sformatf("v%0d busy_at_done", idx), busy, 0);
        if (v.glitch) begin
            start = 1'b1;
            base_addr = 15'h0000;
            length = 16'd1;
            @(posedge clk_74a);
            #2;
            start = 1'b0;
            @(negedge clk_74a);
            check($sformatf("v%0d start_in_done_ignored", idx), busy, 0);
        end
        repeat (4) @(posedge clk_74a);
        #2;
        for (int i = 0; i < v.exp.len(); i++) begin
            if (v.exp[i] == 8'h7C) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end else exp_q.push_back(v.exp[i]);
        end
        ok = (got_q.size() == exp_q.size());
        if (ok) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL v%0d stream: got \"%s\" expected \"%s\"", idx, to_text(got_q),
                     to_text(exp_q));
        end
        check($sformatf("v%0d mem_rd_count", idx), rd_cnt, 32'(v.len));
        check($sformatf("v%0d done_pulses", idx), done_cnt, 1);
        check($sformatf("v%0d stall_stability_errors", idx), stab_err, 0);
        ok = (addr_log.size() == int'(v.len));
        if (ok) foreach (addr_log[i]) if (addr_log[i] !== 15'(v.base + 15'(i))) ok = 1'b0;
        check($sformatf("v%0d addr_seq", idx), ok, 1);
    endtask

    initial begin
        int  nv;
        bit  found, idle_ok;
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        out_ready = 1'b0;

        set_vec(0, 15'h0010, 16'd3, 1, 0, 1'b0, ":03001000010203E7|:00000001FF|");
        set_vec(1, 15'h0123, 16'd0, 0, 0, 1'b0, ":00000001FF|");
        set_vec(2, 15'h0000, 16'd17, 0, 0, 1'b0,
                ":10000000000102030405060708090A0B0C0D0E0F78|:0100100010DF|:00000001FF|");
        set_vec(3, 15'h7FFF, 16'd2, 2, 0, 1'b0, ":027FFF00ABCD08|:00000001FF|");
        set_vec(4, 15'h0010, 16'd3, 1, 1, 1'b1, ":03001000010203E7|:00000001FF|");
        set_vec(5, 15'h7FFE, 16'd3, 0, 1, 1'b0, ":037FFE00FEFF0083|:00000001FF|");

        repeat (3) @(posedge clk_74a);
        @(negedge clk_74a);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset mem_rd", mem_rd, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset mem_addr", mem_addr, 0);
        @(posedge clk_74a);
        #2;
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset during DATA_L of the first record.
        fill_mem(1);
        ready_mode = 0;
        @(posedge clk_74a);
        #2;
        start = 1'b1;
        base_addr = 15'h0010;
        length = 16'd3;
        @(posedge clk_74a);
        #2;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk_74a);
            if (mem_rd) found = 1'b1;
        end
        nv = 0;
        for (int c = 0; c < 200 && nv < 2; c++) begin
            @(negedge clk_74a);
            if (out_valid) nv++;
        end
        check("reach_data_l", nv, 2);
        check("data_l_char", out_data, 8'h31);
        reset_n = 1'b0;
        @(posedge clk_74a);
        #2;
        reset_n = 1'b1;
        @(negedge clk_74a);
        check("midreset busy", busy, 0);
        check("midreset out_valid", out_valid, 0);
        check("midreset out_data", out_data, 0);
        check("midreset mem_addr", mem_addr, 0);
        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge clk_74a);
            if (busy || out_valid || mem_rd) idle_ok = 1'b0;
        end
        check("midreset no_resume", idle_ok, 1);
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d",
                 checks, errors);
        $fatal(1);
    end

endmodule
